noise_inject_ctrl: RTL and testbench
====================================

Name: noise_inject_ctrl

Overview:
Sequencer for multi-channel noise injection on single-bit signal lines. Accepts a campaign configuration through a valid/ready handshake: channel mask, period, pulse offset, pulse count and mode. Then forces one-cycle '1' pulses onto the selected channels at a fixed phase of a repeating period, in broadcast or round-robin order. Sits between the test-control register block and the per-channel signal paths; replaces free-running per-channel injectors with one counted, abortable scheduler.

Parameters:
NCH, 4, number of injectable channels (>=1)
PERIOD_W, 8, width of period/offset/phase counter
CNT_W, 8, width of pulse-count and injected-count fields

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
cfg_valid  in  1  configuration offered
cfg_ready  out  1  configuration accepted when high with cfg_valid
cfg_mask  in  NCH  channels eligible for injection
cfg_period  in  PERIOD_W  cycle length minus one (P => P+1 cycles)
cfg_offset  in  PERIOD_W  phase within period at which a pulse fires
cfg_count  in  CNT_W  pulses to inject; 0 = run until abort
cfg_rr  in  1  0 = broadcast to all masked channels, 1 = round-robin
abort  in  1  terminate campaign
sig_in  in  NCH  clean signals
sig_out  out  NCH  sig_in OR injected pulse, combinational
busy  out  1  high in RUN
done  out  1  one-cycle pulse on normal completion
cfg_err  out  1  one-cycle pulse on rejected configuration
inj_cnt  out  CNT_W  pulses injected in current/last campaign

Behaviour:
- Reset (rst_n=0 at edge): state IDLE, phase=0, inj_cnt=0, rr pointer=0, done=0, cfg_err=0, busy=0, cfg_ready=1, sig_out=sig_in.
- FSM IDLE -> RUN -> DONE -> IDLE; cfg_ready = (state==IDLE).
- IDLE: on cfg_valid at edge, validate. Reject if cfg_mask==0 or cfg_offset>cfg_period: cfg_err=1 next cycle, stay IDLE, nothing latched. Otherwise latch all cfg_* fields, inj_cnt=0, phase=0, rr pointer = lowest set mask bit, go RUN.
- RUN: phase increments each cycle, wraps P->0. fire = (phase==offset) && !abort.
- sig_out[i] = sig_in[i] | (fire && sel[i]). Broadcast: sel = mask. Round-robin: sel = one-hot rr pointer.
- First pulse appears in the cycle offset+1 cycles after the accepting edge, i.e. RUN cycle index offset. P=0 means a pulse every cycle.
- On each edge with fire: inj_cnt += 1 (saturating at all-ones). In round-robin, the pointer advances to the next set mask bit above the current one, wrapping to the lowest.
- Completion: the edge where fire && count!=0 && inj_cnt+1==count moves to DONE. DONE lasts exactly one cycle with done=1, busy=0, no injection, then IDLE.
- abort high in RUN: no injection that cycle, next state IDLE, no done, inj_cnt holds. Abort in IDLE/DONE is ignored.
- Simultaneous abort and final pulse: abort wins; pulse suppressed, no done.
- cfg_valid during RUN/DONE: not accepted (cfg_ready=0), no error.
- Reset mid-RUN: the campaign is dropped immediately at the edge, and outputs follow the reset values.
- inj_cnt remains readable in IDLE until the next accepted configuration.

Decomposition:
- Package noise_inject_pkg: state enum {IDLE, RUN, DONE}, default widths, mode constants MODE_BCAST/MODE_RR.
- Sub-module rr_next_sel (NCH): combinational next-set-bit-with-wrap given mask and current one-hot pointer. Reused by the lowest-set-bit initialisation with pointer=0.

Test Plan:
- Reset, then mask=4'b0001, P=10, offset=5, count=3, broadcast -> sig_out[0] pulses in RUN cycles 5, 16, 27; done one cycle after cycle 27; inj_cnt=3; busy low after.
- mask=4'b1010, P=3, offset=0, count=4, rr=1 -> pulses on ch1, ch3, ch1, ch3 at RUN cycles 0, 4, 8, 12; no other channel affected; sig_in=4'b0100 passes through unchanged on ch2.
- mask=0 or offset=7 with P=5 -> cfg_err pulse, cfg_ready stays 1, busy stays 0, no injection.
- count=0, P=1, offset=1 -> pulse every other cycle; abort asserted on a pulse cycle -> that pulse suppressed, IDLE next cycle, no done, inj_cnt frozen.
- P=0, count=2 -> pulses in RUN cycles 0 and 1, done in cycle 2.
- rst_n low mid-RUN after 2 of 5 pulses -> next cycle IDLE, inj_cnt=0, sig_out==sig_in, cfg_ready=1.

Source files
------------

// File: rtl/noise_inject_pkg.sv
// Shared types and defaults for the noise injection sequencer.
package noise_inject_pkg;

    localparam int NCH_DEF      = 4;
    localparam int PERIOD_W_DEF = 8;
    localparam int CNT_W_DEF    = 8;

    localparam logic MODE_BCAST = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/noise_inject_ctrl_if.sv
// Campaign configuration handshake between test-control registers and the sequencer.
interface noise_inject_ctrl_if #(
    parameter int NCH      = 4,
    parameter int PERIOD_W = 8,
    parameter int CNT_W    = 8
);
    logic                valid;
    logic                ready;
    logic [NCH-1:0]      mask;
    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] offset;
    logic [CNT_W-1:0]    count;
    logic                rr;

    modport master (
        output valid, mask, period, offset, count, rr,
        input  ready
    );

    modport slave (
        input  valid, mask, period, offset, count, rr,
        output ready
    );
endinterface

// File: rtl/noise_inject_ctrl_rr_next_sel.sv
// Next set mask bit strictly above the one-hot pointer, wrapping to the lowest set bit.
// An all-zero pointer yields the lowest set bit.
module rr_next_sel #(
    parameter int NCH = 4
) (
    input  logic [NCH-1:0] mask,
    input  logic [NCH-1:0] ptr,
    output logic [NCH-1:0] nxt
);
    logic           seen;
    logic           hit_above;
    logic           hit_low;
    logic [NCH-1:0] above;
    logic [NCH-1:0] lowest;

    always_comb begin
        seen      = 1'b0;
        hit_above = 1'b0;
        hit_low   = 1'b0;
        above     = '0;
        lowest    = '0;
        for (int i = 0; i < NCH; i++) begin
            if (seen && mask[i] && !hit_above) begin
                above[i]  = 1'b1;
                hit_above = 1'b1;
            end
            if (mask[i] && !hit_low) begin
                lowest[i] = 1'b1;
                hit_low   = 1'b1;
            end
            if (ptr[i]) begin
                seen = 1'b1;
            end
        end
        nxt = hit_above ? above : lowest;
    end
endmodule

// File: rtl/noise_inject_ctrl.sv
// Counted, abortable scheduler forcing one-cycle pulses onto selected signal lines.
//
// state | meaning
// IDLE  | waiting for a configuration; last inj_cnt remains visible
// RUN   | phase counter running, pulse fires when phase == offset
// DONE  | one-cycle completion strobe, no injection
module noise_inject_ctrl
    import noise_inject_pkg::*;
#(
    parameter int NCH      = NCH_DEF,
    parameter int PERIOD_W = PERIOD_W_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    noise_inject_ctrl_if.slave  cfg,
    input  logic                abort,
    input  logic [NCH-1:0]      sig_in,
    output logic [NCH-1:0]      sig_out,
    output logic                busy,
    output logic                done,
    output logic                cfg_err,
    output logic [CNT_W-1:0]    inj_cnt
);
    localparam logic [NCH-1:0] NO_PTR = '0;

    state_t              state_q, state_d;
    logic [NCH-1:0]      mask_q, ptr_q, ptr_adv, ptr_init, sel;
    logic [PERIOD_W-1:0] period_q, offset_q, phase_q;
    logic [CNT_W-1:0]    count_q, inj_cnt_q;
    logic                rr_q, cfg_err_q;
    logic                accept, reject, fire, last;

    rr_next_sel #(.NCH(NCH)) u_adv (
        .mask (mask_q),
        .ptr  (ptr_q),
        .nxt  (ptr_adv)
    );

    rr_next_sel #(.NCH(NCH)) u_init (
        .mask (cfg.mask),
        .ptr  (NO_PTR),
        .nxt  (ptr_init)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        reject  = 1'b0;
        accept  = 1'b0;
        fire    = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg.valid) begin
                    reject = (cfg.mask == '0) || (cfg.offset > cfg.period);
                    accept = !reject;
                end
                if (accept) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                fire = (phase_q == offset_q) && !abort;
                last = fire && (count_q != '0) && ((inj_cnt_q + CNT_W'(1)) == count_q);
                if (abort) begin
                    state_d = IDLE;
                end else if (last) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Abort freezes everything except the state; the phase restarts on the next accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask_q    <= '0;
            period_q  <= '0;
            offset_q  <= '0;
            count_q   <= '0;
            rr_q      <= MODE_BCAST;
            phase_q   <= '0;
            inj_cnt_q <= '0;
            ptr_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= reject;
            if (accept) begin
                mask_q    <= cfg.mask;
                period_q  <= cfg.period;
                offset_q  <= cfg.offset;
                count_q   <= cfg.count;
                rr_q      <= cfg.rr;
                phase_q   <= '0;
                inj_cnt_q <= '0;
                ptr_q     <= ptr_init;
            end else if (state_q == RUN && !abort) begin
                phase_q <= (phase_q == period_q) ? '0 : phase_q + PERIOD_W'(1);
                if (fire) begin
                    if (inj_cnt_q != '1) begin
                        inj_cnt_q <= inj_cnt_q + CNT_W'(1);
                    end
                    if (rr_q == MODE_RR) begin
                        ptr_q <= ptr_adv;
                    end
                end
            end
        end
    end

    assign sel       = (rr_q == MODE_RR) ? ptr_q : mask_q;
    assign sig_out   = sig_in | ({NCH{fire}} & sel);
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign cfg.ready = (state_q == IDLE);
    assign cfg_err   = cfg_err_q;
    assign inj_cnt   = inj_cnt_q;

endmodule

// File: tb/tb_noise_inject_ctrl.sv
// Directed bench for noise_inject_ctrl with hand-computed expectations.
module tb_noise_inject_ctrl;
    localparam int NCH = 4;
    localparam int PW  = 8;
    localparam int CW  = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           abort;
    logic [NCH-1:0] sig_in;
    logic [NCH-1:0] sig_out;
    logic           busy, done, cfg_err;
    logic [CW-1:0]  inj_cnt;
    logic [NCH-1:0] exp_out;

    int vectors     = 0;
    int miscompares = 0;

    noise_inject_ctrl_if #(.NCH(NCH), .PERIOD_W(PW), .CNT_W(CW)) cfg_if ();

    noise_inject_ctrl #(.NCH(NCH), .PERIOD_W(PW), .CNT_W(CW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cfg     (cfg_if),
        .abort   (abort),
        .sig_in  (sig_in),
        .sig_out (sig_out),
        .busy    (busy),
        .done    (done),
        .cfg_err (cfg_err),
        .inj_cnt (inj_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(negedge clk);
    endtask

    task automatic offer(input logic [NCH-1:0] m, input logic [PW-1:0] p,
                         input logic [PW-1:0] o, input logic [CW-1:0] c, input logic r);
        cfg_if.valid  = 1'b1;
        cfg_if.mask   = m;
        cfg_if.period = p;
        cfg_if.offset = o;
        cfg_if.count  = c;
        cfg_if.rr     = r;
    endtask

    initial begin
        rst_n  = 1'b0;
        abort  = 1'b0;
        sig_in = 4'b0110;
        cfg_if.valid  = 1'b0;
        cfg_if.mask   = '0;
        cfg_if.period = '0;
        cfg_if.offset = '0;
        cfg_if.count  = '0;
        cfg_if.rr     = 1'b0;

        // reset
        next_cyc();
        #1;
        chk("rst_ready",   32'(cfg_if.ready), 32'd1);
        chk("rst_busy",    32'(busy),         32'd0);
        chk("rst_done",    32'(done),         32'd0);
        chk("rst_cfg_err", 32'(cfg_err),      32'd0);
        chk("rst_inj_cnt", 32'(inj_cnt),      32'd0);
        chk("rst_sig_out", 32'(sig_out),      32'h6);
        rst_n = 1'b1;

        // broadcast, P=10, offset=5, count=3 -> pulses at RUN cycles 5,16,27
        sig_in = 4'b0110;
        offer(4'b0001, 8'd10, 8'd5, 8'd3, 1'b0);
        next_cyc();
        cfg_if.valid = 1'b0;
        for (int r = 0; r < 28; r++) begin
            #1;
            exp_out = (r == 5 || r == 16 || r == 27) ? 4'b0111 : 4'b0110;
            chk("t1_sig_out", 32'(sig_out), 32'(exp_out));
            if (r == 0) chk("t1_busy", 32'(busy), 32'd1);
            if (r == 0) chk("t1_ready", 32'(cfg_if.ready), 32'd0);
            next_cyc();
        end
        #1;
        chk("t1_done",      32'(done),    32'd1);
        chk("t1_done_busy", 32'(busy),    32'd0);
        chk("t1_done_cnt",  32'(inj_cnt), 32'd3);
        chk("t1_done_out",  32'(sig_out), 32'h6);
        next_cyc();
        #1;
        chk("t1_idle_done",  32'(done),          32'd0);
        chk("t1_idle_ready", 32'(cfg_if.ready),  32'd1);
        chk("t1_idle_cnt",   32'(inj_cnt),       32'd3);

        // round-robin mask=1010, P=3, offset=0, count=4 -> ch1,ch3,ch1,ch3
        sig_in = 4'b0100;
        offer(4'b1010, 8'd3, 8'd0, 8'd4, 1'b1);
        next_cyc();
        cfg_if.valid = 1'b0;
        for (int r = 0; r < 13; r++) begin
            #1;
            if (r % 4 == 0) exp_out = ((r / 4) % 2 == 0) ? 4'b0110 : 4'b1100;
            else            exp_out = 4'b0100;
            chk("t2_sig_out", 32'(sig_out), 32'(exp_out));
            next_cyc();
        end
        #1;
        chk("t2_done",     32'(done),    32'd1);
        chk("t2_done_cnt", 32'(inj_cnt), 32'd4);
        chk("t2_done_out", 32'(sig_out), 32'h4);
        next_cyc();

        // rejected configurations: mask=0, then offset > period
        sig_in = 4'b1001;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) offer(4'b0000, 8'd5, 8'd2, 8'd1, 1'b0);
            else        offer(4'b1111, 8'd5, 8'd7, 8'd1, 1'b0);
            next_cyc();
            cfg_if.valid = 1'b0;
            #1;
            chk("t3_err",     32'(cfg_err),      32'd1);
            chk("t3_ready",   32'(cfg_if.ready), 32'd1);
            chk("t3_busy",    32'(busy),         32'd0);
            chk("t3_sig_out", 32'(sig_out),      32'h9);
            chk("t3_cnt",     32'(inj_cnt),      32'd4);
            next_cyc();
            #1;
            chk("t3_err_gone", 32'(cfg_err), 32'd0);
            chk("t3_busy2",    32'(busy),    32'd0);
            chk("t3_sig_out2", 32'(sig_out), 32'h9);
            next_cyc();
        end

        // count=0, P=1, offset=1: pulse every odd cycle, abort on cycle 5
        sig_in = 4'b0000;
        offer(4'b0011, 8'd1, 8'd1, 8'd0, 1'b0);
        next_cyc();
        cfg_if.valid = 1'b0;
        for (int r = 0; r < 5; r++) begin
            if (r == 2) offer(4'b0000, 8'd1, 8'd1, 8'd0, 1'b0);
            if (r == 3) cfg_if.valid = 1'b0;
            #1;
            exp_out = (r % 2 == 1) ? 4'b0011 : 4'b0000;
            chk("t4_sig_out", 32'(sig_out), 32'(exp_out));
            if (r == 2) chk("t4_ready_run", 32'(cfg_if.ready), 32'd0);
            if (r == 3) chk("t4_no_err",    32'(cfg_err),      32'd0);
            next_cyc();
        end
        abort = 1'b1;
        #1;
        chk("t4_abort_out", 32'(sig_out), 32'h0);
        chk("t4_abort_cnt", 32'(inj_cnt), 32'd2);
        next_cyc();
        abort = 1'b0;
        #1;
        chk("t4_post_busy",  32'(busy),         32'd0);
        chk("t4_post_done",  32'(done),         32'd0);
        chk("t4_post_ready", 32'(cfg_if.ready), 32'd1);
        chk("t4_post_cnt",   32'(inj_cnt),      32'd2);
        next_cyc();
        #1;
        chk("t4_post_done2", 32'(done),    32'd0);
        chk("t4_post_cnt2",  32'(inj_cnt), 32'd2);

        // P=0, count=2: pulses in cycles 0 and 1, done in cycle 2
        sig_in = 4'b0001;
        offer(4'b0100, 8'd0, 8'd0, 8'd2, 1'b0);
        next_cyc();
        cfg_if.valid = 1'b0;
        #1;
        chk("t5_c0_out", 32'(sig_out), 32'h5);
        next_cyc();
        #1;
        chk("t5_c1_out", 32'(sig_out), 32'h5);
        chk("t5_c1_cnt", 32'(inj_cnt), 32'd1);
        next_cyc();
        #1;
        chk("t5_done",     32'(done),    32'd1);
        chk("t5_done_out", 32'(sig_out), 32'h1);
        chk("t5_done_cnt", 32'(inj_cnt), 32'd2);
        next_cyc();
        #1;
        chk("t5_idle_done",  32'(done),         32'd0);
        chk("t5_idle_ready", 32'(cfg_if.ready), 32'd1);

        // abort coincides with the final pulse: abort wins
        sig_in = 4'b0000;
        offer(4'b0001, 8'd0, 8'd0, 8'd1, 1'b0);
        next_cyc();
        cfg_if.valid = 1'b0;
        abort = 1'b1;
        #1;
        chk("t6_abort_out", 32'(sig_out), 32'h0);
        next_cyc();
        abort = 1'b0;
        #1;
        chk("t6_done", 32'(done),    32'd0);
        chk("t6_busy", 32'(busy),    32'd0);
        chk("t6_cnt",  32'(inj_cnt), 32'd0);
        next_cyc();

        // reset mid-RUN after 2 of 5 pulses (P=2, offset=1 -> pulses at 1,4,7,...)
        sig_in = 4'b0010;
        offer(4'b0001, 8'd2, 8'd1, 8'd5, 1'b0);
        next_cyc();
        cfg_if.valid = 1'b0;
        for (int r = 0; r < 5; r++) begin
            #1;
            exp_out = (r == 1 || r == 4) ? 4'b0011 : 4'b0010;
            chk("t7_sig_out", 32'(sig_out), 32'(exp_out));
            next_cyc();
        end
        #1;
        chk("t7_pre_cnt",  32'(inj_cnt), 32'd2);
        chk("t7_pre_busy", 32'(busy),    32'd1);
        rst_n = 1'b0;
        next_cyc();
        rst_n = 1'b1;
        #1;
        chk("t7_rst_cnt",   32'(inj_cnt),      32'd0);
        chk("t7_rst_ready", 32'(cfg_if.ready), 32'd1);
        chk("t7_rst_busy",  32'(busy),         32'd0);
        chk("t7_rst_done",  32'(done),         32'd0);
        chk("t7_rst_out",   32'(sig_out),      32'h2);
        for (int r = 0; r < 3; r++) begin
            next_cyc();
            #1;
            chk("t7_quiet_out", 32'(sig_out), 32'h2);
            chk("t7_quiet_busy", 32'(busy),   32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
